apb_bridge_nslv: RTL and testbench

- Parametrised AHB-Lite to APB3/APB4 bridge with an integrated N-port slave decoder and response mux.
- Replaces the fixed bridge plus 16-port slave mux pair in the peripheral subsystem.
- Adds byte strobes, decode-miss error response, per-access slave index capture and a registered-read option.
- Sits between the AHB interconnect and the APB peripherals (UARTs, GPIO ports).

---
 rtl/apb_bridge_nslv_pkg.sv | 11 +
 rtl/apb_bridge_nslv_if.sv | 36 +++
 rtl/apb_bridge_nslv_rsp_mux.sv | 26 ++
 rtl/apb_bridge_nslv.sv | 129 ++++++++++++
 tb/tb_apb_bridge_nslv.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_bridge_nslv_pkg.sv
// apb_bridge_pkg: bridge FSM states, AHB HTRANS codes and APB byte-strobe helper
package apb_bridge_pkg;
    typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2} state_t;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    function automatic logic [3:0] strb_gen(input logic [2:0] size, input logic [1:0] a);
        return size == 3'd0 ? 4'b0001 << a : size == 3'd1 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction
endpackage

// File: rtl/apb_bridge_nslv_if.sv
// apb_bridge_nslv_if: AHB-Lite slave side, APB master side and status lines of the bridge
// slave modport = bridge view; master modport = AHB master plus APB peripherals view.
interface apb_bridge_nslv_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_SLV    = 4
);
    logic                    HSEL;
    logic [ADDR_WIDTH-1:0]   HADDR;
    logic [1:0]              HTRANS;
    logic                    HWRITE;
    logic [2:0]              HSIZE;
    logic                    HREADY;
    logic [31:0]             HWDATA;
    logic                    HREADYOUT;
    logic [31:0]             HRDATA;
    logic                    HRESP;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [NUM_SLV-1:0]      PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [31:0]             PWDATA;
    logic [3:0]              PSTRB;
    logic [NUM_SLV*32-1:0]   PRDATA;
    logic [NUM_SLV-1:0]      PREADY;
    logic [NUM_SLV-1:0]      PSLVERR;
    logic                    APBACTIVE;
    logic                    TIMEOUT_IRQ;
    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA, PRDATA, PREADY, PSLVERR,
        output HREADYOUT, HRDATA, HRESP, PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, APBACTIVE, TIMEOUT_IRQ
    );
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA, PRDATA, PREADY, PSLVERR,
        input  HREADYOUT, HRDATA, HRESP, PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, APBACTIVE, TIMEOUT_IRQ
    );
endinterface

// File: rtl/apb_bridge_nslv_rsp_mux.sv
// apb_bridge_rsp_mux: selects one slave's PRDATA/PREADY/PSLVERR by slot; out-of-range slot reads as zero
// Ports: prdata_i/pready_i/pslverr_i concatenated slave responses, slot_i index, *_o selected response.
module apb_bridge_rsp_mux #(
    parameter int NUM_SLV = 4
) (
    input  logic [NUM_SLV*32-1:0] prdata_i,
    input  logic [NUM_SLV-1:0]    pready_i,
    input  logic [NUM_SLV-1:0]    pslverr_i,
    input  logic [3:0]            slot_i,
    output logic [31:0]           rdata_o,
    output logic                  ready_o,
    output logic                  err_o
);
    always_comb begin
        rdata_o = '0;
        ready_o = 1'b0;
        err_o   = 1'b0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (slot_i == 4'(k)) begin
                rdata_o = prdata_i[32*k +: 32];
                ready_o = pready_i[k];
                err_o   = pslverr_i[k];
            end
        end
    end
endmodule

// File: rtl/apb_bridge_nslv.sv
// apb_bridge_nslv: AHB-Lite to APB3/APB4 bridge with N-port slave decode and response mux
// Ports: HCLK, RESETn (async active-low), bus (apb_bridge_nslv_if.slave: AHB slave, APB master,
// APBACTIVE clock-gating hint, TIMEOUT_IRQ). Define APB_TIMEOUT_EN to add the ACCESS watchdog.
module apb_bridge_nslv
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int NUM_SLV        = 4,
    parameter int DEC_LSB        = 12,
    parameter int REGISTER_RDATA = 1,
    parameter int TIMEOUT_CYC    = 255
) (
    input logic              HCLK,
    input logic              RESETn,
    apb_bridge_nslv_if.slave bus
);
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [3:0]            slot_q, slot_d, pstrb_q, pstrb_d, hslot;
    logic [31:0]           pwdata_q, pwdata_d, rdata_q, rdata_d, s_rdata;
    logic                  s_ready, s_err, rd_fast, accept, timeout;

    if (NUM_SLV < 1 || NUM_SLV > 16 || TIMEOUT_CYC < 1 || DEC_LSB + 4 > ADDR_WIDTH) begin : g_bad_cfg
        $error("apb_bridge_nslv: illegal parameter set");
    end

    apb_bridge_rsp_mux #(.NUM_SLV(NUM_SLV)) u_rsp_mux (
        .prdata_i  (bus.PRDATA),
        .pready_i  (bus.PREADY),
        .pslverr_i (bus.PSLVERR),
        .slot_i    (slot_q),
        .rdata_o   (s_rdata),
        .ready_o   (s_ready),
        .err_o     (s_err)
    );

    assign hslot   = bus.HADDR[DEC_LSB+3:DEC_LSB];
    // Unregistered read completing in ACCESS returns data now and frees the bus for a new address
    assign rd_fast = state_q == ACCESS && s_ready && !s_err && !write_q && REGISTER_RDATA == 0;
    assign accept  = (state_q == IDLE || state_q == DONE || rd_fast) && bus.HSEL && bus.HREADY &&
                     (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        slot_d   = slot_q;
        pstrb_d  = pstrb_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            WDATA: begin
                pwdata_d = bus.HWDATA;
                state_d  = SETUP;
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (s_ready) begin
                    // Writes always finish through DONE so HRDATA keeps the last read value
                    state_d = s_err ? ERR1 : (write_q || REGISTER_RDATA != 0) ? DONE : IDLE;
                    rdata_d = (s_err || write_q) ? rdata_q : s_rdata;
                end else if (timeout) begin
                    state_d = ERR1;
                end
            end
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            addr_d  = bus.HADDR;
            write_d = bus.HWRITE;
            slot_d  = hslot;
            pstrb_d = bus.HWRITE ? strb_gen(bus.HSIZE, bus.HADDR[1:0]) : 4'b0000;
            state_d = int'(hslot) >= NUM_SLV ? ERR1 : bus.HWRITE ? WDATA : SETUP;
        end
    end

    always_ff @(posedge HCLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            slot_q   <= '0;
            pstrb_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            slot_q   <= slot_d;
            pstrb_q  <= pstrb_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        irq_q;
    // A PREADY in the final allowed cycle completes normally instead of timing out
    assign timeout = state_q == ACCESS && !s_ready && cnt_q == 16'(TIMEOUT_CYC - 1);
    always_ff @(posedge HCLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt_q <= '0;
            irq_q <= 1'b0;
        end else begin
            cnt_q <= state_q == SETUP ? '0 : (state_q == ACCESS && !s_ready) ? cnt_q + 16'd1 : cnt_q;
            irq_q <= timeout;
        end
    end
    assign bus.TIMEOUT_IRQ = irq_q;
`else
    assign timeout         = 1'b0;
    assign bus.TIMEOUT_IRQ = 1'b0;
`endif

    assign bus.PADDR     = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus.PSEL      = (state_q == SETUP || state_q == ACCESS) ? NUM_SLV'(1) << slot_q : '0;
    assign bus.PENABLE   = state_q == ACCESS;
    assign bus.PWRITE    = write_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSTRB     = pstrb_q;
    assign bus.HREADYOUT = state_q == IDLE || state_q == DONE || state_q == ERR2 || rd_fast;
    assign bus.HRESP     = state_q == ERR1 || state_q == ERR2;
    assign bus.HRDATA    = rd_fast ? s_rdata : rdata_q;
    assign bus.APBACTIVE = state_q != IDLE || accept;
endmodule

// File: tb/tb_apb_bridge_nslv.sv
// tb_apb_bridge_nslv: directed self-checking bench for apb_bridge_nslv (NUM_SLV=4, registered read data)
module tb_apb_bridge_nslv;
    import apb_bridge_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    apb_bridge_nslv_if #(.ADDR_WIDTH(16), .NUM_SLV(4)) bus ();

    apb_bridge_nslv #(
        .ADDR_WIDTH(16), .NUM_SLV(4), .DEC_LSB(12), .REGISTER_RDATA(1), .TIMEOUT_CYC(8)
    ) dut (
        .HCLK   (clk),
        .RESETn (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    assign bus.HREADY = bus.HREADYOUT;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
        bus.HWRITE = 1'b0;
    endtask

    task automatic issue(input logic [15:0] a, input logic w, input logic [2:0] s);
        bus.HSEL   = 1'b1;
        bus.HADDR  = a;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HWRITE = w;
        bus.HSIZE  = s;
    endtask

    task automatic test_reset();
        bus_idle();
        bus.HADDR   = '0;
        bus.HSIZE   = '0;
        bus.HWDATA  = '0;
        bus.PRDATA  = '0;
        bus.PREADY  = '1;
        bus.PSLVERR = '0;
        rst_n = 1'b0;
        #2;
        n_chk++;
        if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0 || bus.HRDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ahb: HREADYOUT=%b HRESP=%b HRDATA=%h want 1 0 00000000", bus.HREADYOUT, bus.HRESP, bus.HRDATA);
        end
        n_chk++;
        if (bus.PSEL !== 4'b0 || bus.PENABLE !== 1'b0 || bus.PWRITE !== 1'b0 || bus.PADDR !== 16'h0 ||
            bus.PWDATA !== 32'h0 || bus.PSTRB !== 4'b0 || bus.TIMEOUT_IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_apb: PSEL=%b PENABLE=%b PWRITE=%b PADDR=%h PWDATA=%h PSTRB=%b IRQ=%b want all zero",
                     bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB, bus.TIMEOUT_IRQ);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.HTRANS = HTRANS_NONSEQ;
        #1;
        n_chk++;
        if (bus.APBACTIVE !== 1'b0) begin
            n_fail++;
            $display("FAIL no_hsel: APBACTIVE=%b want 0", bus.APBACTIVE);
        end
        bus.HSEL   = 1'b1;
        bus.HTRANS = HTRANS_BUSY;
        #1;
        n_chk++;
        if (bus.APBACTIVE !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_trans: APBACTIVE=%b want 0", bus.APBACTIVE);
        end
        tick();
        bus_idle();
        #1;
        n_chk++;
        if (bus.PSEL !== 4'b0 || bus.HREADYOUT !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_no_start: PSEL=%b HREADYOUT=%b want 0000 1", bus.PSEL, bus.HREADYOUT);
        end
    endtask

    task automatic test_write_word();
        bus.PREADY  = '1;
        bus.PSLVERR = '0;
        issue(16'h1008, 1'b1, 3'd2);
        #1;
        n_chk++;
        if (bus.APBACTIVE !== 1'b1 || bus.HREADYOUT !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_addr: APBACTIVE=%b HREADYOUT=%b want 1 1", bus.APBACTIVE, bus.HREADYOUT);
        end
        tick();
        bus_idle();
        bus.HWDATA = 32'hA5A5_1234;
        n_chk++;
        if (bus.HREADYOUT !== 1'b0 || bus.PSEL !== 4'b0) begin
            n_fail++;
            $display("FAIL wr_wdata: HREADYOUT=%b PSEL=%b want 0 0000", bus.HREADYOUT, bus.PSEL);
        end
        tick();
        n_chk++;
        if (bus.PSEL !== 4'b0010 || bus.PENABLE !== 1'b0 || bus.HREADYOUT !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_setup: PSEL=%b PENABLE=%b HREADYOUT=%b want 0010 0 0", bus.PSEL, bus.PENABLE, bus.HREADYOUT);
        end
        n_chk++;
        if (bus.PADDR !== 16'h1008 || bus.PSTRB !== 4'b1111 || bus.PWDATA !== 32'hA5A5_1234 || bus.PWRITE !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_payload: PADDR=%h PSTRB=%b PWDATA=%h PWRITE=%b want 1008 1111 a5a51234 1",
                     bus.PADDR, bus.PSTRB, bus.PWDATA, bus.PWRITE);
        end
        tick();
        n_chk++;
        if (bus.PSEL !== 4'b0010 || bus.PENABLE !== 1'b1 || bus.HREADYOUT !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_access: PSEL=%b PENABLE=%b HREADYOUT=%b want 0010 1 0", bus.PSEL, bus.PENABLE, bus.HREADYOUT);
        end
        tick();
        n_chk++;
        if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0 || bus.PSEL !== 4'b0 || bus.PENABLE !== 1'b0 || bus.HRDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL wr_done: HREADYOUT=%b HRESP=%b PSEL=%b PENABLE=%b HRDATA=%h want 1 0 0000 0 00000000",
                     bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.PENABLE, bus.HRDATA);
        end
        tick();
        n_chk++;
        if (bus.APBACTIVE !== 1'b0 || bus.PADDR !== 16'h1008) begin
            n_fail++;
            $display("FAIL wr_idle: APBACTIVE=%b PADDR=%h want 0 1008", bus.APBACTIVE, bus.PADDR);
        end
    endtask

    task automatic test_strobes();
        logic [15:0] ta    [3] = '{16'h2003, 16'h100E, 16'h3001};
        logic [2:0]  ts    [3] = '{3'd0, 3'd1, 3'd0};
        logic [31:0] td    [3] = '{32'h7700_0000, 32'hBEEF_0000, 32'h0000_5500};
        logic [3:0]  tstrb [3] = '{4'b1000, 4'b1100, 4'b0010};
        logic [3:0]  tsel  [3] = '{4'b0100, 4'b0010, 4'b1000};
        for (int i = 0; i < 3; i++) begin
            issue(ta[i], 1'b1, ts[i]);
            tick();
            bus_idle();
            bus.HWDATA = td[i];
            tick();
            n_chk++;
            if (bus.PSEL !== tsel[i] || bus.PSTRB !== tstrb[i] || bus.PWDATA !== td[i] || bus.PADDR !== {ta[i][15:2], 2'b00}) begin
                n_fail++;
                $display("FAIL strobe_%0d: PSEL=%b PSTRB=%b PWDATA=%h PADDR=%h want %b %b %h %h", i,
                         bus.PSEL, bus.PSTRB, bus.PWDATA, bus.PADDR, tsel[i], tstrb[i], td[i], {ta[i][15:2], 2'b00});
            end
            tick();
            tick();
            tick();
        end
    endtask

    task automatic test_read_wait();
        bus.PRDATA[31:0] = 32'hDEAD_BEEF;
        bus.PREADY       = 4'b1110;
        issue(16'h0010, 1'b0, 3'd2);
        tick();
        bus_idle();
        n_chk++;
        if (bus.PSEL !== 4'b0001 || bus.PENABLE !== 1'b0 || bus.PSTRB !== 4'b0000 || bus.PWRITE !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_setup: PSEL=%b PENABLE=%b PSTRB=%b PWRITE=%b want 0001 0 0000 0", bus.PSEL, bus.PENABLE, bus.PSTRB, bus.PWRITE);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) bus.PREADY = 4'b1111;
            n_chk++;
            if (bus.PSEL !== 4'b0001 || bus.PENABLE !== 1'b1 || bus.HREADYOUT !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_access_%0d: PSEL=%b PENABLE=%b HREADYOUT=%b want 0001 1 0", i, bus.PSEL, bus.PENABLE, bus.HREADYOUT);
            end
        end
        tick();
        n_chk++;
        if (bus.HREADYOUT !== 1'b1 || bus.HRDATA !== 32'hDEAD_BEEF || bus.PSEL !== 4'b0) begin
            n_fail++;
            $display("FAIL rd_done: HREADYOUT=%b HRDATA=%h PSEL=%b want 1 deadbeef 0000", bus.HREADYOUT, bus.HRDATA, bus.PSEL);
        end
        bus.PRDATA[31:0] = 32'h0;
        tick();
        n_chk++;
        if (bus.HRDATA !== 32'hDEAD_BEEF || bus.APBACTIVE !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_hold: HRDATA=%h APBACTIVE=%b want deadbeef 0", bus.HRDATA, bus.APBACTIVE);
        end
    endtask

    task automatic test_decode_miss();
        issue(16'h5000, 1'b0, 3'd2);
        tick();
        bus_idle();
        n_chk++;
        if (bus.PSEL !== 4'b0 || bus.HRESP !== 1'b1 || bus.HREADYOUT !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_err1: PSEL=%b HRESP=%b HREADYOUT=%b want 0000 1 0", bus.PSEL, bus.HRESP, bus.HREADYOUT);
        end
        tick();
        issue(16'h1000, 1'b0, 3'd2);
        n_chk++;
        if (bus.PSEL !== 4'b0 || bus.HRESP !== 1'b1 || bus.HREADYOUT !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_err2: PSEL=%b HRESP=%b HREADYOUT=%b want 0000 1 1", bus.PSEL, bus.HRESP, bus.HREADYOUT);
        end
        tick();
        bus_idle();
        #1;
        n_chk++;
        if (bus.HRESP !== 1'b0 || bus.APBACTIVE !== 1'b0 || bus.PSEL !== 4'b0) begin
            n_fail++;
            $display("FAIL miss_ignore: HRESP=%b APBACTIVE=%b PSEL=%b want 0 0 0000", bus.HRESP, bus.APBACTIVE, bus.PSEL);
        end
    endtask

    task automatic test_slverr();
        bus.PSLVERR = 4'b1000;
        issue(16'h3000, 1'b1, 3'd2);
        tick();
        bus_idle();
        bus.HWDATA = 32'h0BAD_0BAD;
        tick();
        tick();
        n_chk++;
        if (bus.PSEL !== 4'b1000 || bus.PENABLE !== 1'b1) begin
            n_fail++;
            $display("FAIL err_access: PSEL=%b PENABLE=%b want 1000 1", bus.PSEL, bus.PENABLE);
        end
        tick();
        n_chk++;
        if (bus.HRESP !== 1'b1 || bus.HREADYOUT !== 1'b0 || bus.PSEL !== 4'b0) begin
            n_fail++;
            $display("FAIL err_1: HRESP=%b HREADYOUT=%b PSEL=%b want 1 0 0000", bus.HRESP, bus.HREADYOUT, bus.PSEL);
        end
        bus.PSLVERR = 4'b0;
        tick();
        n_chk++;
        if (bus.HRESP !== 1'b1 || bus.HREADYOUT !== 1'b1) begin
            n_fail++;
            $display("FAIL err_2: HRESP=%b HREADYOUT=%b want 1 1", bus.HRESP, bus.HREADYOUT);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.PRDATA[127:96] = 32'h1234_5678;
        bus.PRDATA[63:32]  = 32'hCAFE_F00D;
        bus.PRDATA[31:0]   = 32'h5555_AAAA;
        issue(16'h3004, 1'b0, 3'd2);
        tick();
        bus_idle();
        tick();
        tick();
        issue(16'h1000, 1'b0, 3'd2);
        n_chk++;
        if (bus.HRDATA !== 32'h1234_5678 || bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_rd1: HRDATA=%h HREADYOUT=%b HRESP=%b want 12345678 1 0", bus.HRDATA, bus.HREADYOUT, bus.HRESP);
        end
        tick();
        bus_idle();
        n_chk++;
        if (bus.PSEL !== 4'b0010 || bus.PENABLE !== 1'b0 || bus.PADDR !== 16'h1000) begin
            n_fail++;
            $display("FAIL b2b_setup: PSEL=%b PENABLE=%b PADDR=%h want 0010 0 1000", bus.PSEL, bus.PENABLE, bus.PADDR);
        end
        tick();
        tick();
        issue(16'h0000, 1'b1, 3'd2);
        n_chk++;
        if (bus.HRDATA !== 32'hCAFE_F00D || bus.HREADYOUT !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_rd2: HRDATA=%h HREADYOUT=%b want cafef00d 1", bus.HRDATA, bus.HREADYOUT);
        end
        tick();
        bus_idle();
        bus.HWDATA = 32'h0000_0001;
        tick();
        tick();
        tick();
        n_chk++;
        if (bus.HRDATA !== 32'hCAFE_F00D || bus.HREADYOUT !== 1'b1 || bus.PWDATA !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL wr_keeps_hrdata: HRDATA=%h HREADYOUT=%b PWDATA=%h want cafef00d 1 00000001", bus.HRDATA, bus.HREADYOUT, bus.PWDATA);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.PREADY = 4'b0000;
        issue(16'h2000, 1'b0, 3'd2);
        tick();
        bus_idle();
        tick();
        n_chk++;
        if (bus.PENABLE !== 1'b1 || bus.PSEL !== 4'b0100) begin
            n_fail++;
            $display("FAIL mid_access: PENABLE=%b PSEL=%b want 1 0100", bus.PENABLE, bus.PSEL);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.PSEL !== 4'b0 || bus.PENABLE !== 1'b0 || bus.HREADYOUT !== 1'b1 || bus.HRDATA !== 32'h0 ||
            bus.PADDR !== 16'h0 || bus.PWDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset: PSEL=%b PENABLE=%b HREADYOUT=%b HRDATA=%h PADDR=%h PWDATA=%h want 0000 0 1 0 0 0",
                     bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRDATA, bus.PADDR, bus.PWDATA);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        bus.PREADY = 4'b1111;
        tick();
        n_chk++;
        if (bus.APBACTIVE !== 1'b0 || bus.PSEL !== 4'b0) begin
            n_fail++;
            $display("FAIL mid_recover: APBACTIVE=%b PSEL=%b want 0 0000", bus.APBACTIVE, bus.PSEL);
        end
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        int irqs = 0;
        bus.PREADY = 4'b0000;
        issue(16'h2000, 1'b0, 3'd2);
        tick();
        bus_idle();
        for (int i = 0; i < 8; i++) begin
            tick();
            irqs += int'(bus.TIMEOUT_IRQ);
            n_chk++;
            if (bus.PSEL !== 4'b0100 || bus.PENABLE !== 1'b1) begin
                n_fail++;
                $display("FAIL to_access_%0d: PSEL=%b PENABLE=%b want 0100 1", i, bus.PSEL, bus.PENABLE);
            end
        end
        tick();
        irqs += int'(bus.TIMEOUT_IRQ);
        n_chk++;
        if (bus.PSEL !== 4'b0 || bus.PENABLE !== 1'b0 || bus.TIMEOUT_IRQ !== 1'b1 || bus.HRESP !== 1'b1 || bus.HREADYOUT !== 1'b0) begin
            n_fail++;
            $display("FAIL to_abort: PSEL=%b PENABLE=%b IRQ=%b HRESP=%b HREADYOUT=%b want 0000 0 1 1 0",
                     bus.PSEL, bus.PENABLE, bus.TIMEOUT_IRQ, bus.HRESP, bus.HREADYOUT);
        end
        tick();
        irqs += int'(bus.TIMEOUT_IRQ);
        n_chk++;
        if (bus.HRESP !== 1'b1 || bus.HREADYOUT !== 1'b1 || irqs != 1) begin
            n_fail++;
            $display("FAIL to_err2: HRESP=%b HREADYOUT=%b irq_pulses=%0d want 1 1 1", bus.HRESP, bus.HREADYOUT, irqs);
        end
        tick();
        bus.PRDATA[95:64] = 32'h0202_0202;
        issue(16'h2000, 1'b0, 3'd2);
        tick();
        bus_idle();
        for (int i = 0; i < 7; i++) tick();
        tick();
        bus.PREADY = 4'b1111;
        tick();
        n_chk++;
        if (bus.HRESP !== 1'b0 || bus.HREADYOUT !== 1'b1 || bus.TIMEOUT_IRQ !== 1'b0 || bus.HRDATA !== 32'h0202_0202) begin
            n_fail++;
            $display("FAIL to_ready_wins: HRESP=%b HREADYOUT=%b IRQ=%b HRDATA=%h want 0 1 0 02020202",
                     bus.HRESP, bus.HREADYOUT, bus.TIMEOUT_IRQ, bus.HRDATA);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_write_word();
        test_strobes();
        test_read_wait();
        test_decode_miss();
        test_slverr();
        test_back_to_back();
        test_reset_mid();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
